// File: rtl/drp_arb.sv
// drp_arb: round-robin arbiter sharing one DRP master port between PORTS DRP requesters.
// Define DRP_ARB_TIMEOUT_EN to force completion (data 16'hFFFF, timeout_err pulse) after TIMEOUT cycles in WAIT.
module drp_arb #(
   parameter int PORTS      = 2,
   parameter int ADDR_WIDTH = 10,
   parameter int TIMEOUT    = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [PORTS*ADDR_WIDTH-1:0] s_drp_addr,
   input  logic [PORTS*16-1:0]         s_drp_do,
   output logic [PORTS*16-1:0]         s_drp_di,
   input  logic [PORTS-1:0]            s_drp_en,
   input  logic [PORTS-1:0]            s_drp_we,
   output logic [PORTS-1:0]            s_drp_rdy,
   output logic [ADDR_WIDTH-1:0]       m_drp_addr,
   output logic [15:0]                 m_drp_do,
   input  logic [15:0]                 m_drp_di,
   output logic                        m_drp_en,
   output logic                        m_drp_we,
   input  logic                        m_drp_rdy,
   output logic                        busy,
   output logic                        timeout_err
);

   localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;

   if (PORTS < 1 || PORTS > 8 || TIMEOUT < 2) begin : g_param_check
      $error("drp_arb: PORTS must be 1..8 and TIMEOUT at least 2");
   end

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t                state, state_nxt;
   logic [PORTS-1:0]      pending;
   logic [PORTS-1:0]      accept;
   logic [PORTS-1:0]      clr_mask;
   logic [ADDR_WIDTH-1:0] hold_addr [PORTS];
   logic [15:0]           hold_do   [PORTS];
   logic [PORTS-1:0]      hold_we;
   logic [GW-1:0]         grant;
   logic [GW-1:0]         last_grant;
   logic [GW-1:0]         pick;
   logic                  pick_valid;
   logic                  expired;
   logic                  done;

`ifdef DRP_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT) + 1;
   logic [CW-1:0] tmo_cnt;

   // Held at zero outside WAIT, so every WAIT starts counting from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (state != WAIT) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   // A real rdy in the expiry cycle takes priority over the forced completion.
   assign expired = (state == WAIT) && !m_drp_rdy && (tmo_cnt == CW'(TIMEOUT - 1));
`else
   assign expired = 1'b0;
`endif

   assign done = (state == WAIT) && (m_drp_rdy || expired);

   // First pending port after last_grant, wrapping modulo PORTS.
   always_comb begin
      pick       = '0;
      pick_valid = 1'b0;
      for (int k = 1; k <= PORTS; k++) begin
         if (!pick_valid && pending[(int'(last_grant) + k) % PORTS]) begin
            pick       = GW'((int'(last_grant) + k) % PORTS);
            pick_valid = 1'b1;
         end
      end
   end

   // The completing port may re-request in its completion cycle.
   always_comb begin
      clr_mask = '0;
      if (done) begin
         clr_mask[grant] = 1'b1;
      end
      for (int i = 0; i < PORTS; i++) begin
         accept[i] = s_drp_en[i] && (!pending[i] || clr_mask[i]);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_valid) state_nxt = WAIT;
         WAIT:    if (done)       state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending     <= '0;
         hold_we     <= '0;
         grant       <= '0;
         last_grant  <= GW'(PORTS - 1);
         m_drp_addr  <= '0;
         m_drp_do    <= '0;
         m_drp_we    <= 1'b0;
         m_drp_en    <= 1'b0;
         busy        <= 1'b0;
         s_drp_di    <= '0;
         s_drp_rdy   <= '0;
         timeout_err <= 1'b0;
         for (int i = 0; i < PORTS; i++) begin
            hold_addr[i] <= '0;
            hold_do[i]   <= '0;
         end
      end else begin
         m_drp_en    <= 1'b0;
         s_drp_rdy   <= '0;
         timeout_err <= 1'b0;
         pending     <= (pending & ~clr_mask) | accept;
         for (int i = 0; i < PORTS; i++) begin
            if (accept[i]) begin
               hold_addr[i] <= s_drp_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
               hold_do[i]   <= s_drp_do[i*16 +: 16];
               hold_we[i]   <= s_drp_we[i];
            end
         end
         if (state == IDLE && pick_valid) begin
            grant      <= pick;
            m_drp_addr <= hold_addr[pick];
            m_drp_do   <= hold_do[pick];
            m_drp_we   <= hold_we[pick];
            m_drp_en   <= 1'b1;
            busy       <= 1'b1;
         end
         if (done) begin
            s_drp_di[int'(grant)*16 +: 16] <= m_drp_rdy ? m_drp_di : 16'hFFFF;
            s_drp_rdy[grant]               <= 1'b1;
            last_grant                     <= grant;
            busy                           <= 1'b0;
            timeout_err                    <= expired;
         end
      end
   end

endmodule

// File: tb/tb_drp_arb.sv
// tb_drp_arb: directed scenarios plus a randomized run against a cycle-level reference model.
// Handshake: s_drp_en is a one-cycle request pulse, s_drp_rdy a one-cycle completion pulse.
module tb_drp_arb;

   localparam int P   = 3;
   localparam int AW  = 10;
   localparam int TMO = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [P*AW-1:0] s_drp_addr = '0;
   logic [P*16-1:0] s_drp_do = '0;
   logic [P*16-1:0] s_drp_di;
   logic [P-1:0]    s_drp_en = '0;
   logic [P-1:0]    s_drp_we = '0;
   logic [P-1:0]    s_drp_rdy;
   logic [AW-1:0]   m_drp_addr;
   logic [15:0]     m_drp_do;
   logic [15:0]     m_drp_di = '0;
   logic            m_drp_en;
   logic            m_drp_we;
   logic            m_drp_rdy = 1'b0;
   logic            busy;
   logic            timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   drp_arb #(.PORTS(P), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .s_drp_addr(s_drp_addr), .s_drp_do(s_drp_do), .s_drp_di(s_drp_di),
      .s_drp_en(s_drp_en), .s_drp_we(s_drp_we), .s_drp_rdy(s_drp_rdy),
      .m_drp_addr(m_drp_addr), .m_drp_do(m_drp_do), .m_drp_di(m_drp_di),
      .m_drp_en(m_drp_en), .m_drp_we(m_drp_we), .m_drp_rdy(m_drp_rdy),
      .busy(busy), .timeout_err(timeout_err)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // driver tasks (all work on the falling edge)
   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; s_drp_en = '0; m_drp_rdy = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic set_req(input int p, input logic [AW-1:0] a, input logic [15:0] d, input logic w);
      s_drp_addr[p*AW +: AW] = a;
      s_drp_do[p*16 +: 16]   = d;
      s_drp_we[p]            = w;
      s_drp_en[p]            = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      n_tests++; if (m_drp_en !== 1'b0) begin n_fail++; $display("FAIL reset_m_en: got %b expected 0", m_drp_en); end
      n_tests++; if (m_drp_addr !== '0) begin n_fail++; $display("FAIL reset_m_addr: got %h expected 0", m_drp_addr); end
      n_tests++; if (m_drp_do !== '0) begin n_fail++; $display("FAIL reset_m_do: got %h expected 0", m_drp_do); end
      n_tests++; if (m_drp_we !== 1'b0) begin n_fail++; $display("FAIL reset_m_we: got %b expected 0", m_drp_we); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_tests++; if (s_drp_rdy !== '0) begin n_fail++; $display("FAIL reset_s_rdy: got %b expected 0", s_drp_rdy); end
      n_tests++; if (s_drp_di !== '0) begin n_fail++; $display("FAIL reset_s_di: got %h expected 0", s_drp_di); end
      n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %b expected 0", timeout_err); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_read();
      apply_reset();
      set_req(0, 10'h05A, 16'h0000, 1'b0);
      @(negedge clk); s_drp_en = '0;
      n_tests++; if (m_drp_en !== 1'b0) begin n_fail++; $display("FAIL read_early_en: got %b expected 0", m_drp_en); end
      @(negedge clk);
      n_tests++; if (m_drp_en !== 1'b1) begin n_fail++; $display("FAIL read_en: got %b expected 1", m_drp_en); end
      n_tests++; if (m_drp_addr !== 10'h05A) begin n_fail++; $display("FAIL read_addr: got %h expected 05a", m_drp_addr); end
      n_tests++; if (m_drp_we !== 1'b0) begin n_fail++; $display("FAIL read_we: got %b expected 0", m_drp_we); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL read_busy: got %b expected 1", busy); end
      @(negedge clk);
      n_tests++; if (m_drp_en !== 1'b0) begin n_fail++; $display("FAIL read_en_pulse: got %b expected 0", m_drp_en); end
      @(negedge clk);
      @(negedge clk); m_drp_rdy = 1'b1; m_drp_di = 16'h1234;
      @(negedge clk); m_drp_rdy = 1'b0;
      n_tests++; if (s_drp_rdy !== 3'b001) begin n_fail++; $display("FAIL read_s_rdy: got %b expected 001", s_drp_rdy); end
      n_tests++; if (s_drp_di[15:0] !== 16'h1234) begin n_fail++; $display("FAIL read_s_di: got %h expected 1234", s_drp_di[15:0]); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_busy_clr: got %b expected 0", busy); end
      @(negedge clk);
      n_tests++; if (s_drp_rdy !== 3'b000) begin n_fail++; $display("FAIL read_rdy_pulse: got %b expected 000", s_drp_rdy); end
      n_tests++; if (s_drp_di[15:0] !== 16'h1234) begin n_fail++; $display("FAIL read_di_hold: got %h expected 1234", s_drp_di[15:0]); end
   endtask

   task automatic test_write();
      set_req(1, 10'h3FF, 16'hBEEF, 1'b1);
      @(negedge clk); s_drp_en = '0;
      @(negedge clk);
      n_tests++; if (m_drp_en !== 1'b1) begin n_fail++; $display("FAIL write_en: got %b expected 1", m_drp_en); end
      n_tests++; if (m_drp_we !== 1'b1) begin n_fail++; $display("FAIL write_we: got %b expected 1", m_drp_we); end
      n_tests++; if (m_drp_do !== 16'hBEEF) begin n_fail++; $display("FAIL write_do: got %h expected beef", m_drp_do); end
      n_tests++; if (m_drp_addr !== 10'h3FF) begin n_fail++; $display("FAIL write_addr: got %h expected 3ff", m_drp_addr); end
      @(negedge clk);
      n_tests++; if (m_drp_en !== 1'b0) begin n_fail++; $display("FAIL write_en_pulse: got %b expected 0", m_drp_en); end
      m_drp_rdy = 1'b1; m_drp_di = 16'hCAFE;
      @(negedge clk); m_drp_rdy = 1'b0;
      n_tests++; if (s_drp_rdy !== 3'b010) begin n_fail++; $display("FAIL write_s_rdy: got %b expected 010", s_drp_rdy); end
      n_tests++; if (s_drp_di[31:16] !== 16'hCAFE) begin n_fail++; $display("FAIL write_s_di: got %h expected cafe", s_drp_di[31:16]); end
      n_tests++; if (s_drp_di[15:0] !== 16'h1234) begin n_fail++; $display("FAIL write_other_di: got %h expected 1234", s_drp_di[15:0]); end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      set_req(0, 10'h011, 16'h0000, 1'b0);
      set_req(1, 10'h022, 16'h0000, 1'b0);
      @(negedge clk); s_drp_en = '0;
      @(negedge clk);
      n_tests++; if (m_drp_en !== 1'b1 || m_drp_addr !== 10'h011) begin n_fail++; $display("FAIL sim_first: got en=%b addr=%h expected en=1 addr=011", m_drp_en, m_drp_addr); end
      @(negedge clk);
      n_tests++; if (m_drp_en !== 1'b0) begin n_fail++; $display("FAIL sim_no_second_en: got %b expected 0", m_drp_en); end
      @(negedge clk); m_drp_rdy = 1'b1; m_drp_di = 16'hA0A0;
      @(negedge clk); m_drp_rdy = 1'b0;
      n_tests++; if (s_drp_rdy !== 3'b001) begin n_fail++; $display("FAIL sim_rdy0: got %b expected 001", s_drp_rdy); end
      n_tests++; if (m_drp_en !== 1'b0) begin n_fail++; $display("FAIL sim_gap: got %b expected 0", m_drp_en); end
      @(negedge clk);
      n_tests++; if (m_drp_en !== 1'b1 || m_drp_addr !== 10'h022) begin n_fail++; $display("FAIL sim_second: got en=%b addr=%h expected en=1 addr=022", m_drp_en, m_drp_addr); end
      @(negedge clk); m_drp_rdy = 1'b1; m_drp_di = 16'hB0B0;
      @(negedge clk); m_drp_rdy = 1'b0;
      n_tests++; if (s_drp_rdy !== 3'b010) begin n_fail++; $display("FAIL sim_rdy1: got %b expected 010", s_drp_rdy); end
      n_tests++; if (s_drp_di[31:16] !== 16'hB0B0) begin n_fail++; $display("FAIL sim_di1: got %h expected b0b0", s_drp_di[31:16]); end
   endtask

   task automatic test_alternate();
      apply_reset();
      set_req(0, 10'h100, 16'h0000, 1'b0);
      set_req(1, 10'h101, 16'h0000, 1'b0);
      @(negedge clk); s_drp_en = '0;
      for (int g = 0; g < 4; g++) begin
         int w = 0;
         int ep = g % 2;
         while (m_drp_en !== 1'b1 && w < 10) begin @(negedge clk); w++; end
         n_tests++; if (w >= 10) begin n_fail++; $display("FAIL alt_wait_en: got no m_drp_en within 10 cycles expected a grant"); end
         n_tests++; if (m_drp_addr !== AW'(10'h100 + ep)) begin n_fail++; $display("FAIL alt_order[%0d]: got addr %h expected %h", g, m_drp_addr, AW'(10'h100 + ep)); end
         @(negedge clk);
         m_drp_rdy = 1'b1; m_drp_di = 16'(g);
         s_drp_en[ep] = 1'b1;
         @(negedge clk); m_drp_rdy = 1'b0; s_drp_en = '0;
         n_tests++; if (s_drp_rdy !== 3'(1 << ep)) begin n_fail++; $display("FAIL alt_rdy[%0d]: got %b expected %b", g, s_drp_rdy, 3'(1 << ep)); end
      end
   endtask

   task automatic test_reset_mid_wait();
      apply_reset();
      set_req(2, 10'h2AA, 16'h5555, 1'b1);
      @(negedge clk); s_drp_en = '0;
      @(negedge clk);
      n_tests++; if (m_drp_en !== 1'b1) begin n_fail++; $display("FAIL rmw_en: got %b expected 1", m_drp_en); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_tests++; if (m_drp_addr !== '0 || m_drp_do !== '0 || m_drp_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmw_async_clear: got addr=%h do=%h we=%b busy=%b expected all 0", m_drp_addr, m_drp_do, m_drp_we, busy); end
      @(negedge clk); rst = 1'b0;
      @(negedge clk); m_drp_rdy = 1'b1; m_drp_di = 16'h7777;
      @(negedge clk); m_drp_rdy = 1'b0;
      n_tests++; if (s_drp_rdy !== 3'b000) begin n_fail++; $display("FAIL rmw_late_rdy: got %b expected 000", s_drp_rdy); end
      n_tests++; if (s_drp_di !== '0) begin n_fail++; $display("FAIL rmw_late_di: got %h expected 0", s_drp_di); end
      set_req(2, 10'h155, 16'h0000, 1'b0);
      @(negedge clk); s_drp_en = '0;
      n_tests++; if (s_drp_rdy !== 3'b000 || m_drp_en !== 1'b0) begin n_fail++; $display("FAIL rmw_quiet: got rdy=%b en=%b expected 000/0", s_drp_rdy, m_drp_en); end
      @(negedge clk);
      n_tests++; if (m_drp_en !== 1'b1 || m_drp_addr !== 10'h155) begin n_fail++; $display("FAIL rmw_fresh_en: got en=%b addr=%h expected en=1 addr=155", m_drp_en, m_drp_addr); end
      @(negedge clk); m_drp_rdy = 1'b1; m_drp_di = 16'h4242;
      @(negedge clk); m_drp_rdy = 1'b0;
      n_tests++; if (s_drp_rdy !== 3'b100 || s_drp_di[47:32] !== 16'h4242) begin n_fail++; $display("FAIL rmw_fresh_done: got rdy=%b di=%h expected 100/4242", s_drp_rdy, s_drp_di[47:32]); end
   endtask

`ifdef DRP_ARB_TIMEOUT_EN
   task automatic test_timeout();
      apply_reset();
      set_req(0, 10'h0AB, 16'h0000, 1'b0);
      set_req(1, 10'h0CD, 16'h0000, 1'b0);
      @(negedge clk); s_drp_en = '0;
      @(negedge clk);
      n_tests++; if (m_drp_en !== 1'b1 || m_drp_addr !== 10'h0AB) begin n_fail++; $display("FAIL tmo_first_en: got en=%b addr=%h expected 1/0ab", m_drp_en, m_drp_addr); end
      for (int k = 1; k <= TMO - 1; k++) begin
         @(negedge clk);
         n_tests++; if (s_drp_rdy !== 3'b000 || timeout_err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL tmo_wait[%0d]: got rdy=%b err=%b busy=%b expected 000/0/1", k, s_drp_rdy, timeout_err, busy); end
      end
      @(negedge clk);
      n_tests++; if (s_drp_rdy !== 3'b001 || s_drp_di[15:0] !== 16'hFFFF) begin n_fail++; $display("FAIL tmo_force: got rdy=%b di=%h expected 001/ffff", s_drp_rdy, s_drp_di[15:0]); end
      n_tests++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_err: got err=%b busy=%b expected 1/0", timeout_err, busy); end
      @(negedge clk);
      n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_err_pulse: got %b expected 0", timeout_err); end
      n_tests++; if (m_drp_en !== 1'b1 || m_drp_addr !== 10'h0CD) begin n_fail++; $display("FAIL tmo_next_en: got en=%b addr=%h expected 1/0cd", m_drp_en, m_drp_addr); end
      @(negedge clk); m_drp_rdy = 1'b1; m_drp_di = 16'h5A5A;
      @(negedge clk); m_drp_rdy = 1'b0;
      n_tests++; if (s_drp_rdy !== 3'b010 || s_drp_di[31:16] !== 16'h5A5A || timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_next_done: got rdy=%b di=%h err=%b expected 010/5a5a/0", s_drp_rdy, s_drp_di[31:16], timeout_err); end
      set_req(2, 10'h0EF, 16'h0000, 1'b0);
      @(negedge clk); s_drp_en = '0;
      @(negedge clk);
      n_tests++; if (m_drp_en !== 1'b1) begin n_fail++; $display("FAIL tmo_race_en: got %b expected 1", m_drp_en); end
      repeat (TMO - 1) @(negedge clk);
      m_drp_rdy = 1'b1; m_drp_di = 16'h1111;
      @(negedge clk); m_drp_rdy = 1'b0;
      n_tests++; if (s_drp_rdy !== 3'b100 || s_drp_di[47:32] !== 16'h1111 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_race: got rdy=%b di=%h err=%b expected 100/1111/0", s_drp_rdy, s_drp_di[47:32], timeout_err); end
      @(negedge clk); m_drp_rdy = 1'b1;
      @(negedge clk); m_drp_rdy = 1'b0;
      n_tests++; if (s_drp_rdy !== 3'b000 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_stray: got rdy=%b err=%b expected 000/0", s_drp_rdy, timeout_err); end
   endtask
`endif

   // Randomized traffic: the model tracks each port's open request and its cycle of arrival,
   // issues the round-robin winner once eligible, and predicts every pulse and data word.
   task automatic test_random(input int n_cycles);
      logic [AW-1:0] r_addr [P];
      logic [15:0]   r_do   [P];
      logic          r_we   [P];
      bit            r_valid[P];
      int            r_cyc  [P];
      logic [15:0]   e_di   [P];
      logic [P*16-1:0] exp_di_vec;
      logic [P-1:0]  exp_rdy;
      logic [15:0]   data;
      int last_g, out_p, rdy_at, last_rdy, show_at, show_p, exp_g;
      bit exp_en;
      apply_reset();
      for (int i = 0; i < P; i++) begin r_valid[i] = 0; e_di[i] = '0; r_addr[i] = '0; r_do[i] = '0; r_we[i] = 0; r_cyc[i] = 0; end
      last_g = P - 1; out_p = -1; rdy_at = 0; last_rdy = -10; show_at = -10; show_p = 0;
      for (int cyc = 0; cyc < n_cycles + 40; cyc++) begin
         s_drp_en = '0; m_drp_rdy = 1'b0;
         exp_g = -1;
         if (out_p < 0 && cyc >= last_rdy + 2) begin
            for (int k = 1; k <= P; k++) begin
               int idx = (last_g + k) % P;
               if (exp_g < 0 && r_valid[idx] && r_cyc[idx] <= cyc - 2) exp_g = idx;
            end
         end
         exp_en = (exp_g >= 0);
         n_tests++; if (m_drp_en !== exp_en) begin n_fail++; $display("FAIL rnd_en@%0d: got %b expected %b", cyc, m_drp_en, exp_en); end
         if (exp_en) begin
            n_tests++;
            if (m_drp_addr !== r_addr[exp_g] || m_drp_do !== r_do[exp_g] || m_drp_we !== r_we[exp_g]) begin
               n_fail++;
               $display("FAIL rnd_issue@%0d: got addr=%h do=%h we=%b expected addr=%h do=%h we=%b (port %0d)",
                        cyc, m_drp_addr, m_drp_do, m_drp_we, r_addr[exp_g], r_do[exp_g], r_we[exp_g], exp_g);
            end
            out_p = exp_g; rdy_at = cyc + int'($urandom_range(1, 4));
         end
         n_tests++; if (busy !== (out_p >= 0)) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b expected %b", cyc, busy, out_p >= 0); end
         exp_rdy = (show_at == cyc) ? P'(1 << show_p) : '0;
         n_tests++; if (s_drp_rdy !== exp_rdy) begin n_fail++; $display("FAIL rnd_rdy@%0d: got %b expected %b", cyc, s_drp_rdy, exp_rdy); end
         for (int i = 0; i < P; i++) exp_di_vec[i*16 +: 16] = e_di[i];
         n_tests++; if (s_drp_di !== exp_di_vec) begin n_fail++; $display("FAIL rnd_di@%0d: got %h expected %h", cyc, s_drp_di, exp_di_vec); end
         n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rnd_tmo@%0d: got %b expected 0", cyc, timeout_err); end
         if (out_p >= 0 && rdy_at == cyc) begin
            data = 16'($urandom);
            m_drp_rdy = 1'b1; m_drp_di = data;
            r_valid[out_p] = 0; last_g = out_p; last_rdy = cyc;
            e_di[out_p] = data; show_at = cyc + 1; show_p = out_p; out_p = -1;
         end else if (out_p < 0 && $urandom_range(0, 9) == 0) begin
            m_drp_rdy = 1'b1; m_drp_di = 16'($urandom);
         end
         if (cyc < n_cycles) begin
            for (int i = 0; i < P; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  if (!r_valid[i]) begin
                     r_addr[i] = AW'($urandom); r_do[i] = 16'($urandom); r_we[i] = 1'($urandom);
                     r_valid[i] = 1; r_cyc[i] = cyc;
                     set_req(i, r_addr[i], r_do[i], r_we[i]);
                  end else if ($urandom_range(0, 3) == 0) begin
                     set_req(i, AW'($urandom), 16'($urandom), 1'($urandom));
                  end
               end
            end
         end
         @(negedge clk);
      end
      s_drp_en = '0; m_drp_rdy = 1'b0;
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_simultaneous();
      test_alternate();
      test_reset_mid_wait();
`ifdef DRP_ARB_TIMEOUT_EN
      test_timeout();
`endif
      test_random(400);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
